sync_fifo_param: RTL
====================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO; next generation of the team's 8x8 sync FIFO.
//  Generic WIDTH/DEPTH, almost-full/almost-empty thresholds, a registered read-valid strobe.
//  Well-defined full/empty behaviour under simultaneous read and write.
//  Sits between producer and consumer stages in the same clock domain.
// PARAMETERS
//  WIDTH     8   data word width in bits (>=1)
//  DEPTH     16  number of entries; power of two, >=2
//  AF_LEVEL  14  almost_full asserts when count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL  2   almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
//  Derived: AW = $clog2(DEPTH) pointer width; CW = AW+1 count width
// PORTS
//  clk           in   1      rising-edge clock; the only clock
//  rst           in   1      synchronous, active-high reset
//  wr_en         in   1      write request
//  data_in       in   WIDTH  write data, sampled when the write is accepted
//  rd_en         in   1      read request
//  data_out      out  WIDTH  read data, registered
//  rd_valid      out  1      data_out holds a freshly read word this cycle
//  empty         out  1      count == 0
//  full          out  1      count == DEPTH
//  almost_empty  out  1      count <= AE_LEVEL
//  almost_full   out  1      count >= AF_LEVEL
//  fifo_count    out  CW     number of stored words, 0..DEPTH
// BEHAVIOUR
//  - Reset: wr_ptr, rd_ptr and fifo_count = 0; rd_valid = 0; data_out = 0.
//    Flags follow: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0).
//    Reset mid-operation discards all contents; RAM is not cleared.
//  - wr_ok = wr_en & (~full | rd_en). rd_ok = rd_en & ~empty.
//  - The full-and-read-and-write case is allowed: the read frees a slot in the same cycle.
//  - Empty with rd_en and wr_en: the write is accepted and the read is rejected.
//    No fall-through.
//  - wr_ok: mem[wr_ptr] <= data_in; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
//  - rd_ok: data_out <= mem[rd_ptr] on the next edge (1-cycle latency); rd_ptr <= rd_ptr+1.
//    rd_valid is 1 for exactly that following cycle.
//    With no rd_ok, data_out holds its value and rd_valid = 0.
//  - fifo_count update: +1 if wr_ok & ~rd_ok; -1 if rd_ok & ~wr_ok; unchanged otherwise.
//    fifo_count never exceeds DEPTH and never underflows.
//  - All flags are combinational decodes of the registered fifo_count.
//  - Same-address read and write in one cycle cannot happen unless count is 0 or DEPTH.
//    When count==DEPTH, the read returns the old word (read-before-write).
//  - Requests that are not accepted (write while full without read, read while empty) are ignored.
//    They do not change any state.
// CONFIGURATION
//  SYNC_FIFO_ERR_EN defined:
//  - Adds outputs overflow and underflow, each 1 bit. Both reset to 0.
//  - overflow <= 1 on any cycle with wr_en & ~wr_ok.
//  - underflow <= 1 on any cycle with rd_en & ~rd_ok.
//  - Both are sticky until rst.
//  SYNC_FIFO_ERR_EN undefined: the ports and logic are absent; rejected requests are silent.
// STRUCTURE
//  - Package sync_fifo_pkg: clog2 helper function; parameter legality checks.
//    The checks are elaboration-time errors for non-power-of-two DEPTH or out-of-range levels.
//  - Sub-module fifo_ram_dp: DEPTH x WIDTH RAM.
//    Synchronous write port (we, waddr, wdata) and registered synchronous read port (re, raddr, rdata).
//    The read port holds rdata when re=0.
//  - Top holds the pointers, the counter, the flag decode and rd_valid.
// TESTING (WIDTH=8, DEPTH=16, AF=14, AE=2 unless stated)
//  1 Reset, then 16 writes 0x00..0x0F:
//    - count steps 0..16; almost_full rises at count 14; full rises at count 16.
//    - 17th write 0xAA is ignored (overflow=1 with SYNC_FIFO_ERR_EN); count stays 16.
//  2 From full, 16 reads:
//    - data_out = 0x00..0x0F, each one cycle after its rd_en, with rd_valid high.
//    - empty=1 after the last read; a 17th read gives rd_valid=0 and data_out holds 0x0F.
//    - With SYNC_FIFO_ERR_EN: underflow=1.
//  3 Full, then rd_en and wr_en together with data_in 0x55:
//    - count stays 16; data_out = oldest word.
//    - 0x55 is read out last after draining.
//  4 Empty, then rd_en and wr_en together with 0x77:
//    - count becomes 1; rd_valid=0.
//    - The next read returns 0x77.
//  5 Wrap-around: 1000 random cycles with reference-model scoreboard:
//    - pointers wrap repeatedly; data order is preserved.
//    - The flags match the model every cycle.
//  6 Assert rst with count=9, mid-burst:
//    - next cycle count=0, empty=1, rd_valid=0.
//    - The next read returns data written after reset.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared helpers for sync_fifo_param: pointer-width calculation and the
// elaboration-time legality check applied to the FIFO parameters.
package sync_fifo_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int width, input int depth,
                                   input int af_level, input int ae_level);
    return (width >= 1) && is_pow2(depth) &&
           (af_level >= 1) && (af_level <= depth) &&
           (ae_level >= 0) && (ae_level <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_param_ram.sv
// DEPTH x WIDTH dual-port RAM: synchronous write, registered read that holds
// rdata while re is low. A same-address read and write returns the old word.
module fifo_ram_dp #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with almost flags and registered read data.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       data_out,
  output logic                   rd_valid,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_empty,
  output logic                   almost_full,
`ifdef SYNC_FIFO_ERR_EN
  output logic                   overflow,
  output logic                   underflow,
`endif
  output logic [clog2(DEPTH):0]  fifo_count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  if (!params_ok(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
    $error("sync_fifo_param: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL");
  end

  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg, count_next;
  logic             rd_valid_reg;
  logic             out_live_reg;
  logic             wr_ok, rd_ok;
  logic [WIDTH-1:0] ram_rdata;

  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_en);

  always_comb begin
    count_next = count_reg;
    if (wr_ok && !rd_ok)      count_next = count_reg + CW'(1);
    else if (rd_ok && !wr_ok) count_next = count_reg - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      rd_valid_reg <= 1'b0;
      out_live_reg <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_ok) begin
        rd_ptr_reg   <= rd_ptr_reg + AW'(1);
        out_live_reg <= 1'b1;
      end
      count_reg    <= count_next;
      rd_valid_reg <= rd_ok;
    end
  end

  fifo_ram_dp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr_reg),
    .wdata (data_in),
    .re    (rd_ok),
    .raddr (rd_ptr_reg),
    .rdata (ram_rdata)
  );

  // The RAM output register carries no reset, so data_out reads as zero
  // until the first read after reset has refreshed it.
  assign data_out     = out_live_reg ? ram_rdata : '0;
  assign rd_valid     = rd_valid_reg;
  assign fifo_count   = count_reg;
  assign empty        = (count_reg == '0);
  assign full         = (count_reg == CW'(DEPTH));
  assign almost_empty = (int'(count_reg) <= AE_LEVEL);
  assign almost_full  = (int'(count_reg) >= AF_LEVEL);

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_reg, underflow_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_en && !wr_ok) overflow_reg  <= 1'b1;
      if (rd_en && !rd_ok) underflow_reg <= 1'b1;
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
`endif

endmodule
